// File: rtl/md_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
// Encodings follow the execute-stage mulOrdiv/mdIsSign decode.
package md_pkg;

    localparam int MD_DW = 32;

    // Quotient forced onto LO when the divisor is zero.
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    localparam logic MD_OP_MUL = 1'b0;
    localparam logic MD_OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } mdState_e;

endpackage

// File: rtl/md_if.sv
// Execute-stage <-> multiply/divide sequencer handshake and result bus.
interface md_if
    import md_pkg::*;
#(
    parameter int DW = MD_DW
);
    logic          start_i;
    logic          op_div_i;
    logic          is_signed_i;
    logic [DW-1:0] a_i;
    logic [DW-1:0] b_i;
    logic          cancel_i;
    logic          stall_ext_i;
    logic          stall_o;
    logic          busy_o;
    logic          result_valid_o;
    logic [DW-1:0] hi_o;
    logic [DW-1:0] lo_o;

    modport master (
        output start_i, op_div_i, is_signed_i, a_i, b_i, cancel_i, stall_ext_i,
        input  stall_o, busy_o, result_valid_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_div_i, is_signed_i, a_i, b_i, cancel_i, stall_ext_i,
        output stall_o, busy_o, result_valid_o, hi_o, lo_o
    );
endinterface

// File: rtl/md_div_core.sv
// Iterative restoring radix-2 divider on unsigned magnitudes, one step per enabled cycle.
// quotient/remainder present the result of the step taken this cycle; done flags the last one.
module md_div_core
    import md_pkg::*;
#(
    parameter int DW = MD_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stepEn,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [DW-1:0] remainder
);
    localparam int CW = $clog2(DW + 1);

    logic [DW-1:0] remR;
    logic [DW-1:0] quoR;
    logic [DW-1:0] dvsR;
    logic [CW-1:0] cnt;
    logic [DW:0]   trial;

    // Partial remainder stays below the divisor, so the top bit of the
    // DW+1-bit trial difference is a clean borrow flag.
    always_comb begin
        trial = {remR, quoR[DW-1]} - {1'b0, dvsR};
        if (trial[DW]) begin
            remainder = {remR[DW-2:0], quoR[DW-1]};
            quotient  = {quoR[DW-2:0], 1'b0};
        end else begin
            remainder = trial[DW-1:0];
            quotient  = {quoR[DW-2:0], 1'b1};
        end
    end

    assign done = stepEn && (cnt == CW'(DW - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            remR <= '0;
            quoR <= '0;
            dvsR <= '0;
            cnt  <= '0;
        end else if (start) begin
            remR <= '0;
            quoR <= dividend;
            dvsR <= divisor;
            cnt  <= '0;
        end else if (stepEn) begin
            remR <= remainder;
            quoR <= quotient;
            cnt  <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/md_sequencer.sv
// HI/LO multiply/divide sequencer: launches MULT/MULTU/DIV/DIVU from E, stalls the
// front of the pipe while busy, and holds the 64-bit result in DONE for the HI/LO write.
module md_sequencer
    import md_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int DW      = MD_DW
) (
    input  logic clk,
    input  logic rst,
    md_if.slave  bus
);
    localparam int MCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    mdState_e              state;
    logic [DW-1:0]         aR;
    logic [DW-1:0]         bR;
    logic                  signR;
    logic                  qNeg;
    logic                  rNeg;
    logic [MCW-1:0]        mulCnt;
    logic [DW-1:0]         hiR;
    logic [DW-1:0]         loR;

    logic                  launch;
    logic                  divStart;
    logic                  divStep;
    logic                  divDone;
    logic                  aNeg;
    logic                  bNeg;
    logic [DW-1:0]         divQuo;
    logic [DW-1:0]         divRem;
    logic signed [2*DW-1:0] mulA;
    logic signed [2*DW-1:0] mulB;
    logic signed [2*DW-1:0] prod;

    function automatic logic [DW-1:0] condNeg(input logic [DW-1:0] x, input logic neg);
        return neg ? (DW'(0) - x) : x;
    endfunction

    assign launch   = (state == IDLE) && bus.start_i && !bus.cancel_i;
    assign divStart = launch && (bus.op_div_i == MD_OP_DIV);
    assign divStep  = (state == DIV) && !bus.cancel_i;
    assign aNeg     = bus.is_signed_i && bus.a_i[DW-1];
    assign bNeg     = bus.is_signed_i && bus.b_i[DW-1];

    md_div_core #(.DW(DW)) u_divCore (
        .clk       (clk),
        .rst       (rst),
        .start     (divStart),
        .stepEn    (divStep),
        .dividend  (condNeg(bus.a_i, aNeg)),
        .divisor   (condNeg(bus.b_i, bNeg)),
        .done      (divDone),
        .quotient  (divQuo),
        .remainder (divRem)
    );

    // Extending to 2*DW and keeping the low 2*DW product bits gives the same
    // result as the 33-bit extended multiply truncated to 64 bits.
    always_comb begin
        mulA = signR ? {{DW{aR[DW-1]}}, aR} : {{DW{1'b0}}, aR};
        mulB = signR ? {{DW{bR[DW-1]}}, bR} : {{DW{1'b0}}, bR};
        prod = mulA * mulB;
    end

    assign bus.stall_o        = !bus.cancel_i &&
                                (((state == IDLE) && bus.start_i) || (state == MUL) || (state == DIV));
    assign bus.busy_o         = (state == MUL) || (state == DIV);
    assign bus.result_valid_o = (state == DONE);
    assign bus.hi_o           = hiR;
    assign bus.lo_o           = loR;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            aR     <= '0;
            bR     <= '0;
            signR  <= 1'b0;
            qNeg   <= 1'b0;
            rNeg   <= 1'b0;
            mulCnt <= '0;
            hiR    <= '0;
            loR    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        aR     <= bus.a_i;
                        bR     <= bus.b_i;
                        signR  <= bus.is_signed_i;
                        qNeg   <= aNeg ^ bNeg;
                        rNeg   <= aNeg;
                        mulCnt <= '0;
                        case (bus.op_div_i)
                            MD_OP_MUL: state <= MUL;
                            MD_OP_DIV: state <= DIV;
                        endcase
                    end
                end
                MUL: begin
                    if (bus.cancel_i) begin
                        state <= IDLE;
                    end else if (mulCnt == MCW'(MUL_LAT - 1)) begin
                        {hiR, loR} <= prod;
                        state      <= DONE;
                    end else begin
                        mulCnt <= mulCnt + MCW'(1);
                    end
                end
                DIV: begin
                    if (bus.cancel_i) begin
                        state <= IDLE;
                    end else if (divDone) begin
                        // Zero divisor: LO all ones, HI the raw dividend, no sign fix-up.
                        if (bR == '0) begin
                            loR <= DW'(DIV0_LO);
                            hiR <= aR;
                        end else begin
                            loR <= condNeg(divQuo, qNeg);
                            hiR <= condNeg(divRem, rNeg);
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.cancel_i || !bus.stall_ext_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed-vector bench for md_sequencer: latency, stall/busy/valid timing, signed and
// unsigned results, divide-by-zero, overflow, cancel, external stall hold and reset.
module tb_md_sequencer;
    import md_pkg::*;

    localparam int MUL_LAT = 3;
    localparam int DW      = 32;

    logic clk;
    logic rst;
    int   vecCnt;
    int   errCnt;

    md_if #(.DW(DW)) bus ();

    md_sequencer #(.MUL_LAT(MUL_LAT), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic runOp(input string tag, input logic div, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expHi, input logic [31:0] expLo);
        int lat;
        lat = div ? DW : MUL_LAT;
        @(negedge clk);
        bus.start_i     = 1'b1;
        bus.op_div_i    = div;
        bus.is_signed_i = sgn;
        bus.a_i         = a;
        bus.b_i         = b;
        #1;
        checkVal({tag, ".stallT"}, 64'(bus.stall_o), 64'd1);
        checkVal({tag, ".busyT"},  64'(bus.busy_o),  64'd0);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
            #1;
            checkVal({tag, ".stallRun"}, 64'(bus.stall_o),        64'd1);
            checkVal({tag, ".validRun"}, 64'(bus.result_valid_o), 64'd0);
            if (c == 1) checkVal({tag, ".busyRun"}, 64'(bus.busy_o), 64'd1);
        end
        @(negedge clk);
        #1;
        checkVal({tag, ".validDone"}, 64'(bus.result_valid_o), 64'd1);
        checkVal({tag, ".stallDone"}, 64'(bus.stall_o),        64'd0);
        checkVal({tag, ".busyDone"},  64'(bus.busy_o),         64'd0);
        checkVal({tag, ".hi"},        64'(bus.hi_o),           64'(expHi));
        checkVal({tag, ".lo"},        64'(bus.lo_o),           64'(expLo));
        @(negedge clk);
        #1;
        checkVal({tag, ".validAfter"}, 64'(bus.result_valid_o), 64'd0);
    endtask

    initial begin
        vecCnt          = 0;
        errCnt          = 0;
        rst             = 1'b1;
        bus.start_i     = 1'b0;
        bus.op_div_i    = 1'b0;
        bus.is_signed_i = 1'b0;
        bus.a_i         = '0;
        bus.b_i         = '0;
        bus.cancel_i    = 1'b0;
        bus.stall_ext_i = 1'b0;

        @(negedge clk);
        @(negedge clk);
        #1;
        checkVal("rst.stall", 64'(bus.stall_o),        64'd0);
        checkVal("rst.busy",  64'(bus.busy_o),         64'd0);
        checkVal("rst.valid", 64'(bus.result_valid_o), 64'd0);
        checkVal("rst.hi",    64'(bus.hi_o),           64'd0);
        checkVal("rst.lo",    64'(bus.lo_o),           64'd0);
        @(negedge clk);
        rst = 1'b0;

        runOp("mult_m3x5",   1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1);
        runOp("multu_ffsq",  1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        runOp("mult_m1sq",   1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
        runOp("divu_100_7",  1'b1, 1'b0, 32'd100,       32'd7,         32'd2,         32'd14);
        runOp("div_m7_2",    1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        runOp("div_7_m2",    1'b1, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
        runOp("div_ovf",     1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
        runOp("divu_by0",    1'b1, 1'b0, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF);
        runOp("div_m5_by0",  1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF);

        // Cancel a divide in its tenth cycle; previous HI/LO must survive.
        @(negedge clk);
        bus.start_i     = 1'b1;
        bus.op_div_i    = 1'b1;
        bus.is_signed_i = 1'b0;
        bus.a_i         = 32'd100;
        bus.b_i         = 32'd7;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
        end
        @(negedge clk);
        bus.cancel_i = 1'b1;
        #1;
        checkVal("cancel.stall", 64'(bus.stall_o), 64'd0);
        @(negedge clk);
        bus.cancel_i = 1'b0;
        #1;
        checkVal("cancel.busy", 64'(bus.busy_o), 64'd0);
        checkVal("cancel.hi",   64'(bus.hi_o),   64'h0000_0000_FFFF_FFFB);
        checkVal("cancel.lo",   64'(bus.lo_o),   64'h0000_0000_FFFF_FFFF);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            #1;
            checkVal("cancel.noValid", 64'(bus.result_valid_o), 64'd0);
        end

        runOp("multu_6x7", 1'b0, 1'b0, 32'd6, 32'd7, 32'd0, 32'd42);

        // External stall holds DONE; start_i stays high and operands change underneath.
        @(negedge clk);
        bus.start_i     = 1'b1;
        bus.op_div_i    = 1'b0;
        bus.is_signed_i = 1'b0;
        bus.a_i         = 32'h0001_0001;
        bus.b_i         = 32'h0001_0001;
        bus.stall_ext_i = 1'b1;
        for (int c = 1; c <= MUL_LAT; c++) begin
            @(negedge clk);
            bus.a_i = 32'd5;
            bus.b_i = 32'd9;
            #1;
            checkVal("hold.busy", 64'(bus.busy_o), 64'd1);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 3) bus.stall_ext_i = 1'b0;
            #1;
            checkVal("hold.valid", 64'(bus.result_valid_o), 64'd1);
            checkVal("hold.stall", 64'(bus.stall_o),        64'd0);
            checkVal("hold.hi",    64'(bus.hi_o),           64'd1);
            checkVal("hold.lo",    64'(bus.lo_o),           64'h0000_0000_0002_0001);
        end
        @(negedge clk);
        bus.start_i = 1'b0;
        #1;
        checkVal("hold.validEnd", 64'(bus.result_valid_o), 64'd0);
        checkVal("hold.busyEnd",  64'(bus.busy_o),         64'd0);
        checkVal("hold.stallEnd", 64'(bus.stall_o),        64'd0);

        // Reset mid-divide, asserted together with cancel.
        @(negedge clk);
        bus.start_i     = 1'b1;
        bus.op_div_i    = 1'b1;
        bus.a_i         = 32'd100;
        bus.b_i         = 32'd7;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
        end
        @(negedge clk);
        rst          = 1'b1;
        bus.cancel_i = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        bus.cancel_i = 1'b0;
        #1;
        checkVal("midRst.stall", 64'(bus.stall_o),        64'd0);
        checkVal("midRst.busy",  64'(bus.busy_o),         64'd0);
        checkVal("midRst.valid", 64'(bus.result_valid_o), 64'd0);
        checkVal("midRst.hi",    64'(bus.hi_o),           64'd0);
        checkVal("midRst.lo",    64'(bus.lo_o),           64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
